bitrev_driver: RTL and testbench
================================

# bitrev_driver

Initiator-side sequencer for the bit-reversal accelerator. It accepts one 32-bit job from the host over a valid/ready request channel, drives the operand and a start pulse into the accelerator, and waits for its done flag. It then performs NUM_WORDS read handshakes (read held high for two cycles, then low) and returns each result word on a valid/ready result channel. It sits between the GRHEEP host-side bus logic and the accelerator wrapper, and it owns all read-handshake and post-job reset-wait timing.

## Interface

- NUM_WORDS, 4: result words per job; must equal the accelerator's read count.
- READ_GAP, 2: low cycles of read_o after each high phase (≥1).
- RST_WAIT, 4: cycles to wait after reset and after each job's last read, covering the accelerator's self-reset.
- TIMEOUT, 1024: maximum cycles in WAIT_DONE before the job is abandoned.

Ports:

- clk  in  1  single clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; all state and outputs cleared.
- req_valid_i  in  1  host offers a job.
- req_ready_o  out  1  driver accepts a job; high only in IDLE.
- req_data_i  in  32  operand word.
- res_valid_o  out  1  result word available.
- res_ready_i  in  1  host accepts the result word.
- res_data_o  out  32  result word.
- res_last_o  out  1  high with the final word (index NUM_WORDS-1).
- busy_o  out  1  high in every state except IDLE.
- timeout_o  out  1  one-cycle pulse when a job is abandoned.
- din_o  out  32  operand to accelerator; held stable from START until job end.
- start_flag_o  out  1  one-cycle start pulse.
- read_o  out  1  read strobe to accelerator.
- done_flag_i  in  1  accelerator done.
- dout_i  in  32  accelerator result.

## Operation

- Reset value of every output is 0, including din_o and res_data_o. The state after reset is INIT_WAIT.
- **INIT_WAIT:** counts RST_WAIT cycles, then moves to IDLE. req_ready_o is 0.
- **IDLE:** req_ready_o is 1. On req_valid_i & req_ready_o, latch req_data_i into din_o and go to START. done_flag_i is ignored in this state.
- **START:** start_flag_o is 1 for exactly this cycle. Clear word_cnt and the timer, then go to WAIT_DONE.
- **WAIT_DONE:** when done_flag_i is 1, go to READ_HI. Otherwise the timer increments. When the timer reaches TIMEOUT-1, pulse timeout_o, emit no results, and go to IDLE.
- **READ_HI:** read_o is 1 for exactly 2 cycles, then go to READ_GAP.
- **READ_GAP:** read_o is 0 for READ_GAP cycles. On the last gap cycle, capture dout_i into res_data_o, then go to OUTPUT.
- **OUTPUT:** res_valid_o is 1. res_data_o and res_last_o are held stable until res_ready_i is 1.
  - On the handshake, if word_cnt < NUM_WORDS-1: increment word_cnt and go to READ_HI.
  - On the handshake of the last word: go to INIT_WAIT, which provides the accelerator self-reset wait.
- A drop of done_flag_i during READ_HI, READ_GAP or OUTPUT is ignored; the sequence completes.
- read_o is never asserted outside READ_HI. It is therefore always low for at least READ_GAP cycles between high phases, and stays low for any backpressure stall.
- word_cnt width is clog2(NUM_WORDS); it never wraps within a job.
- Reset asserted mid-job aborts immediately: outputs go to 0 and the state goes to INIT_WAIT. The accelerator shares the same system reset.

## Timing

- Request handshake at cycle T gives start_flag_o at T+1. WAIT_DONE begins at T+2.
- done_flag_i first seen high at cycle D:
  - read_o is high at D+1 and D+2.
  - read_o is low at D+3 through D+2+READ_GAP.
  - Capture happens at the end of D+2+READ_GAP.
  - res_valid_o is first high at D+3+READ_GAP.
- With res_ready_i held high, the per-word period is 3+READ_GAP cycles (5 with defaults). The next read_o rises in the cycle after each handshake.
- Last-word handshake at cycle H: INIT_WAIT occupies H+1 through H+RST_WAIT, and req_ready_o is 1 at H+RST_WAIT+1.
- After reset deassertion, req_ready_o first rises on the (RST_WAIT+1)th rising edge.
- Timeout: the timeout_o pulse occurs TIMEOUT cycles after WAIT_DONE is entered, and req_ready_o is 1 in the following cycle.

## Test plan

- **Nominal job.** Stimulus: reset; send req_data_i=0x00000001; the accelerator model asserts done 10 cycles after start and returns 0x80000000, 0x40000000, 0x20000000, 0x10000000. Required response: exactly 4 res words in order, res_last_o only on the 4th, read_o high-phase count = 4, req_ready_o high RST_WAIT+1 cycles after the last handshake.
- **Backpressure.** Stimulus: hold res_ready_i=0 for 7 cycles on word 2. Required response: res_data_o stable, read_o stays 0 throughout, and the next read_o rises the cycle after the handshake.
- **Timeout.** Stimulus: done_flag_i is never asserted. Required response: a single timeout_o pulse exactly TIMEOUT cycles after WAIT_DONE entry, no res_valid_o, then IDLE.
- **Reset mid-read.** Stimulus: assert reset during the second READ_HI cycle of word 1. Required response: all outputs 0 the same cycle; after deassertion req_ready_o first rises on the (RST_WAIT+1)th rising edge, and the next job completes normally.
- **Back-to-back jobs.** Stimulus: req_valid_i held high with 0xAAAAAAAA then 0x0000FFFF. Required response: the second job is accepted only in IDLE after INIT_WAIT; din_o changes only at the acceptance edge; both result streams are correct.
- **Spurious done.** Stimulus: pulse done_flag_i while in IDLE, and drop it during READ_GAP. Required response: IDLE stays idle; the in-progress job still returns all 4 words.

Source files
------------

// File: rtl/bitrev_driver.sv
// Host-side sequencer for the bit-reversal accelerator: one job in,
// NUM_WORDS read handshakes out, with reset-wait and timeout handling.
module bitrev_driver #(
  parameter int NUM_WORDS = 4,
  parameter int READ_GAP  = 2,
  parameter int RST_WAIT  = 4,
  parameter int TIMEOUT   = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_data_i,
  output logic        res_valid_o,
  input  logic        res_ready_i,
  output logic [31:0] res_data_o,
  output logic        res_last_o,
  output logic        busy_o,
  output logic        timeout_o,
  output logic [31:0] din_o,
  output logic        start_flag_o,
  output logic        read_o,
  input  logic        done_flag_i,
  input  logic [31:0] dout_i
);

  localparam int CW =
    $clog2(TIMEOUT + RST_WAIT + READ_GAP + 4);
  localparam int WW =
    (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_START,
    S_WAIT,
    S_RDHI,
    S_GAP,
    S_OUT
  } state_t;

  state_t        r_state, w_state;
  logic [CW-1:0] r_cnt, w_cnt;
  logic [WW-1:0] r_word, w_word;
  logic [31:0]   r_din, w_din;
  logic [31:0]   r_res, w_res;
  logic          r_busy;
  logic          w_last;

  assign din_o      = r_din;
  assign res_data_o = r_res;
  assign busy_o     = r_busy;
  assign w_last     = (r_word == WW'(NUM_WORDS - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_INIT;
      r_cnt   <= '0;
      r_word  <= '0;
      r_din   <= '0;
      r_res   <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_word  <= w_word;
      r_din   <= w_din;
      r_res   <= w_res;
      r_busy  <= (w_state != S_IDLE);
    end
  end

  always_comb begin
    w_state      = r_state;
    w_cnt        = r_cnt;
    w_word       = r_word;
    w_din        = r_din;
    w_res        = r_res;
    req_ready_o  = 1'b0;
    res_valid_o  = 1'b0;
    res_last_o   = 1'b0;
    timeout_o    = 1'b0;
    start_flag_o = 1'b0;
    read_o       = 1'b0;
    unique case (r_state)
      // Reset leaves r_cnt at 0, a job end enters at 1, so the
      // cycle in which reset releases counts as one extra wait.
      S_INIT: begin
        if (r_cnt == CW'(RST_WAIT)) begin
          w_state = S_IDLE;
          w_cnt   = '0;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      S_IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          w_din   = req_data_i;
          w_state = S_START;
        end
      end
      S_START: begin
        start_flag_o = 1'b1;
        w_cnt        = '0;
        w_word       = '0;
        w_state      = S_WAIT;
      end
      S_WAIT: begin
        if (done_flag_i) begin
          w_state = S_RDHI;
          w_cnt   = '0;
        end else if (r_cnt == CW'(TIMEOUT - 1)) begin
          timeout_o = 1'b1;
          w_state   = S_IDLE;
          w_cnt     = '0;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      S_RDHI: begin
        read_o = 1'b1;
        if (r_cnt == CW'(1)) begin
          w_state = S_GAP;
          w_cnt   = '0;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      S_GAP: begin
        if (r_cnt == CW'(READ_GAP - 1)) begin
          w_res   = dout_i;
          w_state = S_OUT;
          w_cnt   = '0;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      S_OUT: begin
        res_valid_o = 1'b1;
        res_last_o  = w_last;
        if (res_ready_i) begin
          if (!w_last) begin
            w_word  = r_word + 1'b1;
            w_state = S_RDHI;
            w_cnt   = '0;
          end else begin
            w_state = S_INIT;
            w_cnt   = CW'(1);
          end
        end
      end
      default: begin
        w_state = S_INIT;
        w_cnt   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_bitrev_driver.sv
// Directed bench for bitrev_driver with a cycle-stepped
// accelerator model driven from the stimulus thread.
module tb_bitrev_driver;

  localparam int NW  = 4;
  localparam int GAP = 2;
  localparam int RW  = 4;
  localparam int TO  = 1024;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic [31:0] req_data = '0;
  logic        res_ready = 1'b1;
  logic        done = 1'b0;
  logic [31:0] dout = '0;

  logic        req_ready_o;
  logic        res_valid_o;
  logic [31:0] res_data_o;
  logic        res_last_o;
  logic        busy_o;
  logic        timeout_o;
  logic [31:0] din_o;
  logic        start_flag_o;
  logic        read_o;

  int total = 0;
  int bad = 0;
  int rd_rises = 0;
  logic rd_prev = 1'b0;

  bitrev_driver #(
    .NUM_WORDS(NW),
    .READ_GAP (GAP),
    .RST_WAIT (RW),
    .TIMEOUT  (TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready_o),
    .req_data_i  (req_data),
    .res_valid_o (res_valid_o),
    .res_ready_i (res_ready),
    .res_data_o  (res_data_o),
    .res_last_o  (res_last_o),
    .busy_o      (busy_o),
    .timeout_o   (timeout_o),
    .din_o       (din_o),
    .start_flag_o(start_flag_o),
    .read_o      (read_o),
    .done_flag_i (done),
    .dout_i      (dout)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (read_o && !rd_prev) rd_rises++;
    rd_prev = read_o;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_ctl", 32'({req_ready_o, res_valid_o,
        res_last_o, busy_o, timeout_o,
        start_flag_o, read_o}), 32'd0);
    chk("rst_din", din_o, 32'd0);
    chk("rst_res", res_data_o, 32'd0);
    tick();
    reset = 1'b0;
    for (int e = 1; e <= RW + 1; e++) begin
      tick();
      chk("rst_rdy_edge", 32'(req_ready_o),
          32'(e == RW + 1));
    end
  endtask

  task automatic do_job(input logic [31:0] op,
                        input logic [3:0][31:0] w,
                        input int stall_w,
                        input int stall_n,
                        input bit drop,
                        input bit nv,
                        input logic [31:0] nd,
                        input int abort_w);
    int n;
    int base;
    n = 0;
    while (!req_ready_o && n < 50) begin
      tick();
      n++;
    end
    chk("accept_rdy", 32'(req_ready_o), 32'd1);
    if (!req_ready_o) return;
    req_valid = 1'b1;
    req_data  = op;
    tick();
    req_valid = nv;
    req_data  = nd;
    base = rd_rises;
    chk("start", 32'(start_flag_o), 32'd1);
    chk("din_latch", din_o, op);
    chk("busy", 32'(busy_o), 32'd1);
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk("wait_quiet", 32'({read_o, res_valid_o,
          start_flag_o, req_ready_o}), 32'd0);
      if (i == 10) done = 1'b1;
    end
    for (int wi = 0; wi < NW; wi++) begin
      tick();
      chk("rd_hi1", 32'(read_o), 32'd1);
      chk("din_hold", din_o, op);
      dout = w[wi];
      tick();
      chk("rd_hi2", 32'(read_o), 32'd1);
      if (wi == abort_w) begin
        done = 1'b0;
        dout = '0;
        do_reset();
        return;
      end
      for (int g = 1; g <= GAP; g++) begin
        tick();
        chk("gap", 32'({read_o, res_valid_o}), 32'd0);
        if (drop && wi == 0 && g == 1) done = 1'b0;
      end
      tick();
      chk("valid", 32'(res_valid_o), 32'd1);
      chk("data", res_data_o, w[wi]);
      chk("last", 32'(res_last_o), 32'(wi == NW - 1));
      dout = 32'hDEAD_BEEF;
      if (wi == stall_w) begin
        res_ready = 1'b0;
        for (int s = 1; s < stall_n; s++) begin
          tick();
          chk("stall_ctl", 32'({res_valid_o, read_o}),
              32'd2);
          chk("stall_data", res_data_o, w[wi]);
        end
        res_ready = 1'b1;
      end
      if (wi == NW - 1) done = 1'b0;
    end
    for (int k = 1; k <= RW; k++) begin
      tick();
      chk("init_wait", 32'({req_ready_o, busy_o}), 32'd1);
      chk("din_keep", din_o, op);
    end
    tick();
    chk("ready_back", 32'(req_ready_o), 32'd1);
    chk("rd_phases", 32'(rd_rises - base), 32'(NW));
  endtask

  task automatic do_timeout();
    int pulses;
    int pcyc;
    int nv;
    pulses = 0;
    pcyc = -1;
    nv = 0;
    req_valid = 1'b1;
    req_data  = 32'h1234_5678;
    tick();
    req_valid = 1'b0;
    chk("to_start", 32'(start_flag_o), 32'd1);
    for (int i = 1; i <= TO; i++) begin
      tick();
      if (timeout_o) begin
        pulses++;
        pcyc = i;
      end
      if (res_valid_o || read_o) nv++;
    end
    chk("to_pulses", 32'(pulses), 32'd1);
    chk("to_when", 32'(pcyc), 32'(TO));
    chk("to_noresult", 32'(nv), 32'd0);
    tick();
    chk("to_idle", 32'({req_ready_o, busy_o}), 32'd2);
  endtask

  initial begin
    do_reset();

    done = 1'b1;
    tick();
    chk("spur_idle", 32'({req_ready_o, busy_o,
        start_flag_o}), 32'd4);
    done = 1'b0;
    tick();
    chk("spur_idle2", 32'({req_ready_o, busy_o,
        start_flag_o}), 32'd4);

    do_job(32'h0000_0001,
      {32'h1000_0000, 32'h2000_0000,
       32'h4000_0000, 32'h8000_0000},
      -1, 0, 1'b0, 1'b0, 32'd0, -1);

    do_job(32'h0000_000F,
      {32'h0F00_0000, 32'h1E00_0000,
       32'h3C00_0000, 32'hF000_0000},
      2, 7, 1'b0, 1'b0, 32'd0, -1);

    do_timeout();

    do_job(32'h8000_0000,
      {32'h0000_0008, 32'h0000_0004,
       32'h0000_0002, 32'h0000_0001},
      -1, 0, 1'b1, 1'b0, 32'd0, -1);

    do_job(32'h0000_0003,
      {32'h3000_0000, 32'h6000_0000,
       32'hC000_0000, 32'hC000_0001},
      -1, 0, 1'b0, 1'b0, 32'd0, 1);

    do_job(32'h0000_0001,
      {32'h1000_0000, 32'h2000_0000,
       32'h4000_0000, 32'h8000_0000},
      -1, 0, 1'b0, 1'b0, 32'd0, -1);

    do_job(32'hAAAA_AAAA,
      {32'h0555_5555, 32'h1555_5555,
       32'h2AAA_AAAA, 32'h5555_5555},
      -1, 0, 1'b0, 1'b1, 32'h0000_FFFF, -1);

    do_job(32'h0000_FFFF,
      {32'h1FFF_E000, 32'h3FFF_C000,
       32'h7FFF_8000, 32'hFFFF_0000},
      -1, 0, 1'b0, 1'b0, 32'd0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
